// File: rtl/vga_layer_compositor_pkg.sv
// Shared VGA timing defaults (1024x768) and RRRGGGBB colour field positions
// for the layer compositor and its sub-blocks.
package vga_layer_compositor_pkg;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

    function automatic logic [7:0] rgb332(input logic [2:0] r, input logic [2:0] g,
                                          input logic [1:0] b);
        logic [7:0] c;
        c = '0;
        c[R_HI:R_LO] = r;
        c[G_HI:G_LO] = g;
        c[B_HI:B_LO] = b;
        return c;
    endfunction

endpackage

// File: rtl/vga_layer_compositor_priority_mux.sv
// Picks the lowest-index layer that is enabled and not keyed out, else the
// background colour.
module vga_priority_mux #(
    parameter int NUM_LAYERS = 8,
    parameter int COLOR_W    = 8,
    parameter int KEY_EN     = 1
) (
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel,
    input  logic [COLOR_W-1:0]            key_color,
    input  logic [COLOR_W-1:0]            bg_color,
    output logic [COLOR_W-1:0]            color
);
    import vga_layer_compositor_pkg::*;

    // Walk from lowest priority upward so the last eligible hit (lowest index) wins.
    always_comb begin
        color = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] &&
                ((KEY_EN == 0) || (layer_pixel[i*COLOR_W +: COLOR_W] != key_color))) begin
                color = layer_pixel[i*COLOR_W +: COLOR_W];
            end
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA timing generator with a two-stage pipeline that composites prioritised
// layers into RGB aligned with registered sync and data-enable outputs.
module vga_layer_compositor
    import vga_layer_compositor_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   NUM_LAYERS = 8,
    parameter int   COLOR_W    = 8,
    parameter int   KEY_EN     = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          video_en,
    input  logic [COLOR_W-1:0]            bg_color,
    input  logic [COLOR_W-1:0]            key_color,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel,
    output logic [10:0]                   h_counter,
    output logic [9:0]                    v_counter,
    output logic                          line_start,
    output logic                          frame_start,
    output logic [7:0]                    frame_cnt,
    output logic [COLOR_W-1:0]            RGB,
    output logic                          Hsync,
    output logic                          Vsync,
    output logic                          de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic        running;
    logic [10:0] h_nxt;
    logic [9:0]  v_nxt;
    logic        frame_wrap;

    logic s1_valid;
    logic s1_active;
    logic s1_hs;
    logic s1_vs;

    logic [COLOR_W-1:0] mux_color;

    // The first cycle after reset holds (0,0) so it is presented with frame_start set.
    always_comb begin
        h_nxt      = h_counter;
        v_nxt      = v_counter;
        frame_wrap = 1'b0;
        if (running) begin
            if (h_counter == H_LAST) begin
                h_nxt = '0;
                if (v_counter == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = v_counter + 10'd1;
                end
            end else begin
                h_nxt = h_counter + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            h_counter   <= '0;
            v_counter   <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            running     <= 1'b1;
            h_counter   <= h_nxt;
            v_counter   <= v_nxt;
            line_start  <= (h_nxt == 11'd0);
            frame_start <= (h_nxt == 11'd0) && (v_nxt == 10'd0);
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    vga_priority_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W),
        .KEY_EN     (KEY_EN)
    ) u_mux (
        .layer_en    (layer_en),
        .layer_pixel (layer_pixel),
        .key_color   (key_color),
        .bg_color    (bg_color),
        .color       (mux_color)
    );

    // Stage 1 decodes regions while the layer sources fetch; stage 2 composites.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_active <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            RGB       <= '0;
            de        <= 1'b0;
            Hsync     <= ~SYNC_POL;
            Vsync     <= ~SYNC_POL;
        end else begin
            s1_valid  <= running;
            s1_active <= (h_counter < H_ACT) && (v_counter < V_ACT);
            s1_hs     <= (h_counter >= HS_START) && (h_counter < HS_END);
            s1_vs     <= (v_counter >= VS_START) && (v_counter < VS_END);
            if (s1_valid && s1_active && video_en) begin
                RGB <= mux_color;
                de  <= 1'b1;
            end else begin
                RGB <= '0;
                de  <= 1'b0;
            end
            Hsync <= (s1_valid && s1_hs) ? SYNC_POL : ~SYNC_POL;
            Vsync <= (s1_valid && s1_vs) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor on a tiny 16x8 timing with
// a vector table feeding a scoreboard of expected composited outputs.
module tb_vga_layer_compositor;

    logic        clk;
    logic        reset_n;
    logic        video_en;
    logic [7:0]  bg_color;
    logic [7:0]  key_color;
    logic [3:0]  layer_en;
    logic [31:0] layer_pixel;
    logic [10:0] h_counter;
    logic [9:0]  v_counter;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_cnt;
    logic [7:0]  RGB;
    logic        Hsync;
    logic        Vsync;
    logic        de;

    vga_layer_compositor #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b0), .NUM_LAYERS (4), .COLOR_W (8), .KEY_EN (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .video_en    (video_en),
        .bg_color    (bg_color),
        .key_color   (key_color),
        .layer_en    (layer_en),
        .layer_pixel (layer_pixel),
        .h_counter   (h_counter),
        .v_counter   (v_counter),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .RGB         (RGB),
        .Hsync       (Hsync),
        .Vsync       (Vsync),
        .de          (de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] pix;
        logic [7:0]  key;
        logic [7:0]  bg;
        logic        vid;
        logic [7:0]  exp_rgb;
    } vec_t;

    typedef struct {
        logic [7:0] rgb;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    localparam int NV = 10;
    vec_t vecs[NV];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit prev_valid = 0;
    int prev_h = 0;
    int prev_v = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_h"}, int'(h_counter), 0);
        check_output({tag, "_v"}, int'(v_counter), 0);
        check_output({tag, "_fcnt"}, int'(frame_cnt), 0);
        check_output({tag, "_rgb"}, int'(RGB), 0);
        check_output({tag, "_de"}, int'(de), 0);
        check_output({tag, "_hsync"}, int'(Hsync), 1);
        check_output({tag, "_vsync"}, int'(Vsync), 1);
        check_output({tag, "_line_start"}, int'(line_start), 0);
        check_output({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        layer_en    = v.en;
        layer_pixel = v.pix;
        key_color   = v.key;
        bg_color    = v.bg;
        video_en    = v.vid;
    endtask

    // One pixel clock: compare outputs, check counters, drive layer data for the previous coordinate.
    task automatic run_cycle();
        int   hm;
        int   vm;
        vec_t v;
        exp_t e;
        bit   act;
        hm = n % 16;
        vm = (n / 16) % 8;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("rgb", int'(RGB), int'(e.rgb));
            check_output("de", int'(de), int'(e.de));
            check_output("hsync", int'(Hsync), int'(e.hs));
            check_output("vsync", int'(Vsync), int'(e.vs));
        end
        check_output("h_counter", int'(h_counter), hm);
        check_output("v_counter", int'(v_counter), vm);
        check_output("line_start", int'(line_start), (hm == 0) ? 1 : 0);
        check_output("frame_start", int'(frame_start), (hm == 0 && vm == 0) ? 1 : 0);
        check_output("frame_cnt", int'(frame_cnt), (n / 128) % 256);

        v = vecs[n % NV];
        apply_stimulus(v);
        if (prev_valid) begin
            act   = (prev_h < 8) && (prev_v < 4);
            e.rgb = act ? v.exp_rgb : 8'h00;
            e.de  = act && v.vid;
            e.hs  = (prev_h >= 10 && prev_h <= 12) ? 1'b0 : 1'b1;
            e.vs  = (prev_v >= 5 && prev_v <= 6) ? 1'b0 : 1'b1;
        end else begin
            e.rgb = 8'h00;
            e.de  = 1'b0;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end
        sb.push_back(e);
        prev_h     = hm;
        prev_v     = vm;
        prev_valid = 1;
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n          = 0;
        prev_valid = 0;
    endtask

    initial begin
        int guard;
        vecs[0] = '{4'b0110, 32'h001CE000, 8'hFF, 8'h03, 1'b1, 8'hE0};
        vecs[1] = '{4'b0110, 32'h001CE000, 8'hE0, 8'h03, 1'b1, 8'h1C};
        vecs[2] = '{4'b0000, 32'h001CE000, 8'hFF, 8'h03, 1'b1, 8'h03};
        vecs[3] = '{4'b1111, 32'h44332211, 8'hFF, 8'h03, 1'b1, 8'h11};
        vecs[4] = '{4'b1111, 32'h44332211, 8'h11, 8'h03, 1'b1, 8'h22};
        vecs[5] = '{4'b1000, 32'h44332211, 8'hFF, 8'h03, 1'b1, 8'h44};
        vecs[6] = '{4'b1000, 32'h44332211, 8'h44, 8'h5A, 1'b1, 8'h5A};
        vecs[7] = '{4'b0101, 32'h00070080, 8'h80, 8'h03, 1'b1, 8'h07};
        vecs[8] = '{4'b1111, 32'h44332211, 8'hFF, 8'h03, 1'b0, 8'h00};
        vecs[9] = '{4'b0110, 32'h001CE000, 8'hFF, 8'h03, 1'b0, 8'h00};

        reset_n = 1'b0;
        apply_stimulus(vecs[3]);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        release_reset();
        for (int i = 0; i < 3 * 128 + 20; i++) begin
            run_cycle();
        end

        // Walk forward to (5,2) and drop reset mid-line.
        guard = 0;
        while (!((n % 16) == 5 && ((n / 16) % 8) == 2) && guard < 200) begin
            run_cycle();
            guard++;
        end
        check_output("reach_h5v2", int'(h_counter == 11'd5 && v_counter == 10'd2), 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        check_reset_values("midreset_hold");

        release_reset();
        check_output("restart_h", int'(h_counter), 0);
        check_output("restart_v", int'(v_counter), 0);
        check_output("restart_frame_start", int'(frame_start), 1);
        for (int i = 0; i < 150; i++) begin
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
